qmult_pipe: RTL and testbench
=============================

// Module: qmult_pipe
// PURPOSE
//  Pipelined signed fixed-point multiplier for the gate datapaths. Output is in the same
//  (N,Q) format as the inputs, e.g. N=16, Q=12 gives S|III|FFFFFFFFFFFF.
//  Adds a valid/ready stream handshake with backpressure, selectable rounding and
//  saturation, and a sticky overflow flag. Intended for MAC and activation chains.
// PARAMETERS
//  N      16  total bits of operands and result (two's complement)
//  Q      12  fractional bits, 1 <= Q <= N-2
//  STAGES 2   pipeline register stages, >= 1; equals latency in cycles when not stalled
//  ROUND  0   0 = truncate toward zero; 1 = round half away from zero
//  SAT    1   1 = clamp out-of-range results; 0 = wrap (keep low N bits)
// PORTS
//  clk         in   1  rising-edge clock
//  rst_n       in   1  asynchronous active-low reset
//  in_valid    in   1  operand pair valid
//  in_ready    out  1  block accepts operands this cycle
//  in_a        in   N  multiplicand, signed Q format
//  in_b        in   N  multiplier, signed Q format
//  out_valid   out  1  result valid
//  out_ready   in   1  downstream accepts result
//  out_q       out  N  product, signed Q format
//  out_ovf     out  1  this result was out of range (qualified by out_valid)
//  ovf_sticky  out  1  some transferred result has overflowed since the last clear
//  clr_sticky  in   1  synchronous clear of ovf_sticky
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_q, out_ovf and ovf_sticky are 0 asynchronously.
//   Reset mid-stream drops all in-flight data. in_ready = 1 after the first edge following release.
//  Handshake: input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
//   out_q, out_ovf and out_valid are registered and hold stable while out_valid & !out_ready.
//  Pipeline: STAGES registers, each with a valid bit. Stage k loads when it is empty or when
//   stage k+1 loads or is transferring out (bubbles collapse).
//   in_ready = !v[0] | stage 0 advancing; it is combinational from out_ready through the chain.
//   No loss, duplication or reordering under any out_ready pattern. Full occupancy = STAGES results.
//   Latency is STAGES cycles from input transfer to out_valid with out_ready held high.
//   Throughput is 1/cycle.
//  Arithmetic:
//   - p = $signed(a) * $signed(b), 2N bits, true two's complement. Correct for -2^(N-1) operands.
//     The result is never a negative zero.
//   - ROUND=0: r = p / 2^Q truncated toward zero.
//   - ROUND=1: add 2^(Q-1) to |p| before truncating, then restore the sign.
//   - Range is [-2^(N-1), 2^(N-1)-1]. If r is outside it, ovf = 1.
//   - On ovf: SAT=1 gives out_q = 0x7FFF.. (positive) or 0x8000.. (negative); SAT=0 gives r[N-1:0].
//   - Placement of the arithmetic among stages is free; only out_* must be registered.
//  Sticky: set on a cycle with out_valid & out_ready & out_ovf; cleared by clr_sticky.
//   If both occur in the same cycle, set wins. A stalled overflow result does not set it.
// TESTING (N=16, Q=12, STAGES=2 unless noted)
//  1.5*2.0: 0x1800,0x2000 -> out_q=0x3000, ovf=0, out_valid exactly 2 cycles after accept.
//   -1.5*2.0: 0xE800,0x2000 -> 0xD000. -1.0*0: 0xF000,0x0000 -> 0x0000.
//  3.0*3.0: 0x3000,0x3000 -> SAT=1: 0x7FFF, ovf=1; SAT=0: 0x9000, ovf=1.
//   -8*-1: 0x8000,0xF000 -> 0x7FFF (SAT=1), ovf=1, ovf_sticky=1 after transfer.
//  Rounding: 0x0001*0x0800 -> ROUND=0: 0x0000; ROUND=1: 0x0001.
//   0xFFFF*0x0800 -> ROUND=0: 0x0000; ROUND=1: 0xFFFF.
//  Backpressure, STAGES=1..4: stream 20 random pairs with out_ready low for cycles 5-14.
//   in_ready drops once STAGES results are held. All 20 results arrive in order and
//   match the reference model. out_q is stable while stalled.
//  Reset: pull rst_n low with a full pipeline and out_ready=0 -> out_valid=0 and
//   ovf_sticky=0 immediately. Nothing emerges after release until new input.
//   Same-cycle clr_sticky with an overflowing transfer -> ovf_sticky stays 1.

Source files
------------

// File: rtl/qmult_pipe.sv
// Pipelined signed fixed-point (N,Q) multiplier with a valid/ready stream interface,
// optional rounding and saturation, and a sticky overflow flag.
module qmult_pipe #(
  parameter int N      = 16,
  parameter int Q      = 12,
  parameter int STAGES = 2,
  parameter int ROUND  = 0,
  parameter int SAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  localparam int W = 2 * N + 1;
  localparam logic [W-1:0] RND     = (ROUND != 0) ? (W'(1) << (Q - 1)) : '0;
  localparam logic [W-1:0] NEG_LIM = W'(1) << (N - 1);
  localparam logic [W-1:0] POS_LIM = (W'(1) << (N - 1)) - W'(1);
  localparam logic [N-1:0] MAX_Q   = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] MIN_Q   = {1'b1, {(N - 1){1'b0}}};

  logic [N-1:0]      data_q [STAGES];
  logic [N-1:0]      data_d [STAGES];
  logic [STAGES-1:0] v_q, v_d, ovf_q, ovf_d, ld;
  logic              rdy_en_q;
  logic              sticky_q, sticky_d;

  logic [2*N-1:0] a_ext, b_ext, prod, mag;
  logic           neg;
  logic [W-1:0]   magr, t;
  logic [N-1:0]   t_lo, wrap, res;
  logic           ovf;

  // Sign-magnitude datapath: the low 2N bits of the unsigned product of the
  // sign-extended operands equal the two's complement product.
  always_comb begin
    a_ext = {{N{in_a[N-1]}}, in_a};
    b_ext = {{N{in_b[N-1]}}, in_b};
    prod  = a_ext * b_ext;
    neg   = prod[2*N-1];
    mag   = neg ? (~prod + (2*N)'(1)) : prod;
    magr  = {1'b0, mag} + RND;
    t     = magr >> Q;
    ovf   = neg ? (t > NEG_LIM) : (t > POS_LIM);
    t_lo  = t[N-1:0];
    wrap  = neg ? (~t_lo + N'(1)) : t_lo;
    if (ovf && (SAT != 0)) begin
      res = neg ? MIN_Q : MAX_Q;
    end else begin
      res = wrap;
    end
  end

  // A stage may load if the output is being drained or any stage at or after it is empty.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v_q[j]) ld[k] = 1'b1;
      end
    end
  end

  assign in_ready = rdy_en_q & ld[0];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign v_d[gi]    = ld[gi] ? (in_valid & in_ready) : v_q[gi];
        assign data_d[gi] = ld[gi] ? res : data_q[gi];
        assign ovf_d[gi]  = ld[gi] ? ovf : ovf_q[gi];
      end else begin : g_next
        assign v_d[gi]    = ld[gi] ? v_q[gi-1]    : v_q[gi];
        assign data_d[gi] = ld[gi] ? data_q[gi-1] : data_q[gi];
        assign ovf_d[gi]  = ld[gi] ? ovf_q[gi-1]  : ovf_q[gi];
      end
    end
  endgenerate

  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (out_valid && out_ready && out_ovf) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      ovf_q    <= '0;
      rdy_en_q <= 1'b0;
      sticky_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      v_q      <= v_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
      sticky_q <= sticky_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign out_valid  = v_q[STAGES-1];
  assign out_q      = data_q[STAGES-1];
  assign out_ovf    = ovf_q[STAGES-1];
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_qmult_pipe.sv
// Directed and backpressure checks of qmult_pipe across four configurations
// (STAGES 1..4, mixed ROUND/SAT).
module tb_qmult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] in_valid, in_ready, out_valid, out_ready, out_ovf, ovf_sticky, clr_sticky;
  logic [3:0][15:0] in_a, in_b, out_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // idx0: S=1 R0 SAT1; idx1: S=2 R0 SAT1; idx2: S=3 R1 SAT0; idx3: S=4 R1 SAT1
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      qmult_pipe #(
        .N(16), .Q(12), .STAGES(gi + 1),
        .ROUND((gi >= 2) ? 1 : 0), .SAT((gi == 2) ? 0 : 1)
      ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
        .in_a(in_a[gi]), .in_b(in_b[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
        .out_q(out_q[gi]), .out_ovf(out_ovf[gi]),
        .ovf_sticky(ovf_sticky[gi]), .clr_sticky(clr_sticky[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input int idx);
    longint p, m, r;
    logic o;
    logic [15:0] q;
    p = longint'($signed(a)) * longint'($signed(b));
    m = (p < 0) ? -p : p;
    if (idx >= 2) m = m + 2048;
    r = m / 4096;
    if (p < 0) r = -r;
    o = (r > 32767) || (r < -32768);
    if (o && idx != 2) q = (r < 0) ? 16'h8000 : 16'h7FFF;
    else q = r[15:0];
    return {o, q};
  endfunction

  task automatic push(input int i, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in_a[i] = a; in_b[i] = b; in_valid[i] = 1'b1;
    #1;
    for (int n = 0; n < 20 && !in_ready[i]; n++) begin
      @(negedge clk); #1;
    end
    chk("push_accept", in_ready[i], 1'b1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic one(input int i, input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] q, output logic o, output int lat);
    @(negedge clk);
    out_ready[i] = 1'b1;
    in_a[i] = a; in_b[i] = b; in_valid[i] = 1'b1;
    #1;
    for (int n = 0; n < 20 && !in_ready[i]; n++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    lat = 1;
    while (!out_valid[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    q = out_q[i];
    o = out_ovf[i];
    $display("dut%0d %h*%h -> q=%h ovf=%0d lat=%0d", i, a, b, q, o, lat);
  endtask

  task automatic dir(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic eo, input string tag);
    logic [15:0] q;
    logic o;
    int lat;
    one(i, a, b, q, o, lat);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_ovf"}, o, eo);
    chk({tag, "_lat"}, lat, i + 1);
  endtask

  task automatic stream(input int i);
    logic [16:0] exp_q[$];
    logic [16:0] e, prev_val;
    logic [15:0] ca, cb;
    logic prev_stall;
    int sent, got;
    sent = 0; got = 0; prev_stall = 1'b0; prev_val = '0;
    ca = 16'($urandom); cb = 16'($urandom);
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      @(negedge clk);
      if (prev_stall) chk("bp_hold", {out_valid[i], out_ovf[i], out_q[i]}, {1'b1, prev_val});
      out_ready[i] = !(cyc >= 5 && cyc <= 14);
      in_valid[i] = (sent < 20);
      in_a[i] = ca; in_b[i] = cb;
      #1;
      if (cyc == 14) begin
        chk("bp_full_ready", in_ready[i], 1'b0);
        chk("bp_full_occ", 32'(sent - got), 32'(i + 1));
      end
      if (in_valid[i] && in_ready[i]) begin
        exp_q.push_back(model(ca, cb, i));
        sent++;
        ca = 16'($urandom); cb = 16'($urandom);
      end
      if (out_valid[i] && out_ready[i]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_FFFF;
        $display("dut%0d stream #%0d q=%h ovf=%0d exp=%h", i, got, out_q[i], out_ovf[i], e);
        chk("bp_result", {out_ovf[i], out_q[i]}, e);
        got++;
      end
      prev_stall = out_valid[i] && !out_ready[i];
      prev_val = {out_ovf[i], out_q[i]};
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    chk("bp_count", got, 20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any;
    in_valid = '0; out_ready = '1; clr_sticky = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_sticky", ovf_sticky, 4'h0);
    chk("rst_out_q", out_q[1], 16'h0);
    chk("rst_in_ready", in_ready, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 4'hF);

    dir(1, 16'h1800, 16'h2000, 16'h3000, 1'b0, "mul_1p5x2");
    dir(1, 16'hE800, 16'h2000, 16'hD000, 1'b0, "mul_m1p5x2");
    dir(1, 16'hF000, 16'h0000, 16'h0000, 1'b0, "mul_m1x0");
    dir(1, 16'h0001, 16'h0800, 16'h0000, 1'b0, "trunc_pos");
    dir(1, 16'hFFFF, 16'h0800, 16'h0000, 1'b0, "trunc_neg");
    @(posedge clk); #1;
    chk("sticky_before", ovf_sticky[1], 1'b0);
    dir(1, 16'h8000, 16'hF000, 16'h7FFF, 1'b1, "sat_m8xm1");
    @(posedge clk); #1;
    chk("sticky_after", ovf_sticky[1], 1'b1);
    dir(1, 16'h3000, 16'h3000, 16'h7FFF, 1'b1, "sat_3x3");

    dir(2, 16'h1800, 16'h2000, 16'h3000, 1'b0, "r1_1p5x2");
    dir(2, 16'h3000, 16'h3000, 16'h9000, 1'b1, "wrap_3x3");
    dir(2, 16'h0001, 16'h0800, 16'h0001, 1'b0, "round_pos");
    dir(2, 16'hFFFF, 16'h0800, 16'hFFFF, 1'b0, "round_neg");

    @(negedge clk) clr_sticky[1] = 1'b1;
    @(posedge clk); #1 clr_sticky[1] = 1'b0;
    chk("sticky_clear", ovf_sticky[1], 1'b0);

    @(negedge clk) out_ready[1] = 1'b0;
    push(1, 16'h3000, 16'h3000);
    push(1, 16'h1800, 16'h2000);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", out_valid[1], 1'b1);
    chk("stall_ovf", out_ovf[1], 1'b1);
    chk("stall_q", out_q[1], 16'h7FFF);
    chk("stall_no_sticky", ovf_sticky[1], 1'b0);
    chk("stall_in_ready", in_ready[1], 1'b0);

    @(negedge clk);
    out_ready[1] = 1'b1; clr_sticky[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0; clr_sticky[1] = 1'b0;
    chk("sticky_set_wins", ovf_sticky[1], 1'b1);
    chk("next_q", out_q[1], 16'h3000);
    push(1, 16'h1000, 16'h1000);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid[1], 1'b0);
    chk("midrst_sticky", ovf_sticky[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready[1] = 1'b1;
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any = any | out_valid[1];
    end
    chk("no_ghost", any, 1'b0);

    for (int i = 0; i < 4; i++) stream(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
